// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: bundle of every non-clock signal of the decode stage.
//   master : upstream side (IF/ID register, control unit, register file,
//            downstream stage status) - drives instruction, decode and
//            register data, observes handshake, branch and ID/EX outputs.
//   slave  : the decode stage itself (id_stage_pipe).
// Parameters must match the ones given to id_stage_pipe.
interface id_stage_pipe_if #(
    parameter int DATA_W      = 32,
    parameter int CMD_W       = 4,
    parameter int STALL_CNT_W = 16
);
    logic [31:0]          instr;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [4:0]           rf_addr1;
    logic [4:0]           rf_addr2;
    logic [DATA_W-1:0]    reg1;
    logic [DATA_W-1:0]    reg2;
    logic                 is_imm;
    logic                 st_or_bne;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 is_br;
    logic                 is_jmp;
    logic [1:0]           br_type;
    logic [CMD_W-1:0]     exe_cmd;
    logic [4:0]           exe_dest;
    logic [4:0]           mem_dest;
    logic                 exe_wb_en;
    logic                 mem_wb_en;
    logic                 exe_mem_r_en;
    logic                 br_taken;
    logic                 hazard;
    logic                 ex_valid;
    logic                 ex_wb_en;
    logic                 ex_mem_r_en;
    logic                 ex_mem_w_en;
    logic [4:0]           ex_dest;
    logic [4:0]           ex_src1;
    logic [4:0]           ex_src2;
    logic [DATA_W-1:0]    ex_val1;
    logic [DATA_W-1:0]    ex_val2;
    logic [DATA_W-1:0]    ex_reg2;
    logic [CMD_W-1:0]     ex_cmd;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output instr, in_valid, flush, reg1, reg2,
               is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en, is_br, is_jmp,
               br_type, exe_cmd, exe_dest, mem_dest, exe_wb_en, mem_wb_en,
               exe_mem_r_en,
        input  in_ready, rf_addr1, rf_addr2, br_taken, hazard,
               ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
               ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_reg2,
               ex_cmd, stall_cnt
    );

    modport slave (
        input  instr, in_valid, flush, reg1, reg2,
               is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en, is_br, is_jmp,
               br_type, exe_cmd, exe_dest, mem_dest, exe_wb_en, mem_wb_en,
               exe_mem_r_en,
        output in_ready, rf_addr1, rf_addr2, br_taken, hazard,
               ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
               ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_reg2,
               ex_cmd, stall_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with built-in ID/EX register.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : id_stage_pipe_if.slave - instruction/decode/register-file inputs,
//          combinational rf_addr1/2, in_ready, hazard, br_taken, and the
//          registered ex_* fields plus saturating stall_cnt.
// Build option: define ID_FWD_EN when a forwarding unit exists downstream;
// only load-use hazards then stall. Without it every pending write to a
// source register in EXE or MEM stalls.
module id_stage_pipe #(
    parameter int DATA_W      = 32,
    parameter int CMD_W       = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    logic [4:0]        w_src1;
    logic [4:0]        w_src2;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_val2;
    logic              w_use2;
    logic              w_m1;
    logic              w_m2;
    logic              w_hazard;
    logic              w_cond;
    logic              w_unused_ok;

    logic                   r_ex_valid;
    logic                   r_ex_wb_en;
    logic                   r_ex_mem_r_en;
    logic                   r_ex_mem_w_en;
    logic [4:0]             r_ex_dest;
    logic [4:0]             r_ex_src1;
    logic [4:0]             r_ex_src2;
    logic [DATA_W-1:0]      r_ex_val1;
    logic [DATA_W-1:0]      r_ex_val2;
    logic [DATA_W-1:0]      r_ex_reg2;
    logic [CMD_W-1:0]       r_ex_cmd;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_src1    = bus.instr[20:16];
    // Stores and BNE read their second operand from the dest field.
    assign w_src2    = bus.st_or_bne ? bus.instr[25:21] : bus.instr[15:11];
    assign w_dest    = bus.instr[25:21];
    assign w_imm_ext = DATA_W'($signed(bus.instr[15:0]));
    assign w_val2    = bus.is_imm ? w_imm_ext : bus.reg2;
    assign w_use2    = !bus.is_imm || bus.st_or_bne;

`ifdef ID_FWD_EN
    // Forwarding covers everything except a load still in EXE.
    assign w_m1 = (w_src1 != 5'd0) && bus.exe_mem_r_en && bus.exe_wb_en &&
                  (w_src1 == bus.exe_dest);
    assign w_m2 = (w_src2 != 5'd0) && bus.exe_mem_r_en && bus.exe_wb_en &&
                  (w_src2 == bus.exe_dest);
    assign w_unused_ok = ^{bus.instr[31:26], bus.mem_dest, bus.mem_wb_en};
`else
    assign w_m1 = (w_src1 != 5'd0) &&
                  ((bus.exe_wb_en && (w_src1 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (w_src1 == bus.mem_dest)));
    assign w_m2 = (w_src2 != 5'd0) &&
                  ((bus.exe_wb_en && (w_src2 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (w_src2 == bus.mem_dest)));
    assign w_unused_ok = ^{bus.instr[31:26], bus.exe_mem_r_en};
`endif

    assign w_hazard = bus.in_valid && (w_m1 || (w_use2 && w_m2));

    always_comb begin
        w_cond = 1'b0;
        case (bus.br_type)
            2'd0:    w_cond = (bus.reg1 == '0);
            2'd1:    w_cond = (bus.reg1 != bus.reg2);
            default: w_cond = 1'b0;
        endcase
    end

    assign bus.hazard   = w_hazard;
    assign bus.in_ready = !w_hazard;
    // A stalled branch is not resolved yet: its operands may be stale.
    assign bus.br_taken = bus.in_valid && !w_hazard &&
                          (bus.is_jmp || (bus.is_br && w_cond));
    assign bus.rf_addr1 = w_src1;
    assign bus.rf_addr2 = w_src2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_wb_en    <= 1'b0;
            r_ex_mem_r_en <= 1'b0;
            r_ex_mem_w_en <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_src1     <= '0;
            r_ex_src2     <= '0;
            r_ex_val1     <= '0;
            r_ex_val2     <= '0;
            r_ex_reg2     <= '0;
            r_ex_cmd      <= '0;
            r_stall_cnt   <= '0;
        end else begin
            // Counts hazard cycles even when a flush hides the bubble.
            if (w_hazard && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);

            if (bus.flush || w_hazard || !bus.in_valid) begin
                // Bubble: only the qualifiers matter, data fields hold.
                r_ex_valid    <= 1'b0;
                r_ex_wb_en    <= 1'b0;
                r_ex_mem_r_en <= 1'b0;
                r_ex_mem_w_en <= 1'b0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_wb_en    <= bus.wb_en;
                r_ex_mem_r_en <= bus.mem_r_en;
                r_ex_mem_w_en <= bus.mem_w_en;
                r_ex_dest     <= w_dest;
                r_ex_src1     <= w_src1;
                r_ex_src2     <= w_src2;
                r_ex_val1     <= bus.reg1;
                r_ex_val2     <= w_val2;
                r_ex_reg2     <= bus.reg2;
                r_ex_cmd      <= bus.exe_cmd;
            end
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_wb_en    = r_ex_wb_en;
    assign bus.ex_mem_r_en = r_ex_mem_r_en;
    assign bus.ex_mem_w_en = r_ex_mem_w_en;
    assign bus.ex_dest     = r_ex_dest;
    assign bus.ex_src1     = r_ex_src1;
    assign bus.ex_src2     = r_ex_src2;
    assign bus.ex_val1     = r_ex_val1;
    assign bus.ex_val2     = r_ex_val2;
    assign bus.ex_reg2     = r_ex_reg2;
    assign bus.ex_cmd      = r_ex_cmd;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule
